// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode seven-segment display controller.
// It stores one hex digit and one decimal point per digit, and has a BCD
// increment/clear engine. One decoder is shared by all digits, which are
// scanned one slot at a time. Each slot starts with a blanking interval to
// stop ghosting between digits.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   wr_en/wr_addr   write wr_data/wr_dp into digit wr_addr (out-of-range ignored)
//   wr_data, wr_dp  digit value 0..F and decimal point (1 = lit)
//   inc             BCD-increment the whole display by one
//   clr             clear all digits and decimal points
//   blank_mask      1 = digit is never lit during its slot
//   seg             active-low segments {dp,g,f,e,d,c,b,a}
//   an              active-low digit enables, at most one low
//   digit_idx       digit currently being scanned
//   ovf             one-cycle pulse when inc wraps the display to zero
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  inc,
  input  logic                  clr,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  ovf
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]      an_q, an_d;
  logic [7:0]                 seg_q, seg_d;
  logic                       ovf_q, ovf_d;
  logic                       carry;
  logic                       terminal_c;

  // Hex to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign terminal_c = (cnt_q == CNT_W'(PRESCALE - 1));

  // Prescaler, scan index and blank/drive FSM.
  always_comb begin
    cnt_d   = terminal_c ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    state_d = state_q;
    if (terminal_c) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    case (state_q)
      ST_BLANK: if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = ST_DRIVE;
      ST_DRIVE: if (terminal_c) state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Digit storage: clr beats wr_en beats inc; losers are dropped.
  always_comb begin
    dig_d = dig_q;
    dp_d  = dp_q;
    ovf_d = 1'b0;
    carry = 1'b1;
    if (clr) begin
      dig_d = '0;
      dp_d  = '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_addr == IDX_W'(i)) begin
          dig_d[i] = wr_data;
          dp_d[i]  = wr_dp;
        end
      end
    end else if (inc) begin
      // Ripple carry; any value >= 9 (including hex A..F) rolls to 0.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (carry) begin
          if (dig_q[i] >= 4'd9) begin
            dig_d[i] = 4'd0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      ovf_d = carry;
    end
  end

  // Pin drive, registered one cycle behind the scan state.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (state_q == ST_DRIVE && !blank_mask[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = {~dp_q[idx_q], seg_decode(dig_q[idx_q])};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      dp_q    <= '0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = idx_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl with a small prescaler. The reference model
// keeps digit values as integers and derives the scan position from the
// number of clock edges since reset.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       inc;
  logic       clr;
  logic [3:0] blank_mask;
  logic [7:0] seg;
  logic [3:0] an;
  logic [1:0] digit_idx;
  logic       ovf;

  seg_scan_ctrl #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B), .IDX_W(2)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dp(wr_dp), .inc(inc), .clr(clr),
    .blank_mask(blank_mask), .seg(seg), .an(an), .digit_idx(digit_idx),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int         passed = 0;
  int         total  = 0;
  int         m_dig[N];
  bit         m_dp[N];
  int         c;
  logic       m_ovf;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic [1:0] e_idx;

  function automatic logic [6:0] seg7(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, land 1 time unit past the edge.
  task automatic step(input bit w, input int a, input int d, input bit dp,
                      input bit i, input bit cl);
    int pos;
    int id;
    int k;
    wr_en = w; wr_addr = 2'(a); wr_data = 4'(d); wr_dp = dp; inc = i; clr = cl;
    pos = c % P;
    id  = (c / P) % N;
    e_an  = 4'hF;
    e_seg = 8'hFF;
    if (pos >= B && !blank_mask[id]) begin
      e_an[id] = 1'b0;
      e_seg    = {~m_dp[id], seg7(m_dig[id])};
    end
    m_ovf = 1'b0;
    if (cl) begin
      foreach (m_dig[j]) begin m_dig[j] = 0; m_dp[j] = 0; end
    end else if (w) begin
      if (a < N) begin m_dig[a] = d; m_dp[a] = dp; end
    end else if (i) begin
      k = -1;
      for (int j = N - 1; j >= 0; j--) if (m_dig[j] < 9) k = j;
      if (k < 0) begin
        foreach (m_dig[j]) m_dig[j] = 0;
        m_ovf = 1'b1;
      end else begin
        for (int j = 0; j < k; j++) m_dig[j] = 0;
        m_dig[k] = m_dig[k] + 1;
      end
    end
    c++;
    e_idx = 2'((c / P) % N);
    @(posedge clk);
    #1;
    wr_en = 1'b0; inc = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
    inc = 1'b0; clr = 1'b0; blank_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    c = 0;
    foreach (m_dig[j]) begin m_dig[j] = 0; m_dp[j] = 0; end
  endtask

  task automatic test_reset();
    logic [3:0] xa;
    logic [7:0] xs;
    do_reset();
    total++;
    if ({an, seg, ovf, digit_idx} !== {4'hF, 8'hFF, 1'b0, 2'd0})
      $display("FAIL reset_values got an=%h seg=%h ovf=%b idx=%0d want an=F seg=FF ovf=0 idx=0",
               an, seg, ovf, digit_idx);
    else passed++;
    for (int t = 1; t <= 11; t++) begin
      step(0, 0, 0, 0, 0, 0);
      xa = (t >= 3 && t <= 8) ? 4'hE : (t == 11) ? 4'hD : 4'hF;
      xs = (xa == 4'hF) ? 8'hFF : 8'hC0;
      total++;
      if (an !== xa || seg !== xs)
        $display("FAIL reset_scan t=%0d got an=%h seg=%h want an=%h seg=%h", t, an, seg, xa, xs);
      else passed++;
    end
  endtask

  task automatic test_write();
    bit seen_b = 0;
    do_reset();
    step(1, 2, 7, 1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx})
        $display("FAIL write_scan c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
      if (an === 4'hB) begin
        seen_b = 1;
        total++;
        if (seg !== 8'h78) $display("FAIL write_seg got seg=%h want seg=78", seg);
        else passed++;
      end
    end
    total++;
    if (!seen_b) $display("FAIL write_slot2 got an=B never seen want an=B in slot 2");
    else passed++;
    // clr and wr_en together: clear wins.
    step(1, 2, 5, 1, 0, 1);
    for (int k = 0; k < 32; k++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx})
        $display("FAIL clr_wins c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
    end
  endtask

  task automatic test_inc_bcd();
    do_reset();
    step(1, 0, 9, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0);
    step(1, 2, 9, 1, 0, 0);
    step(1, 3, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    total++;
    if (ovf !== 1'b0) $display("FAIL inc_no_ovf got ovf=%b want ovf=0", ovf);
    else passed++;
    for (int k = 0; k < 34; k++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx})
        $display("FAIL inc_bcd c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int j = 0; j < N; j++) step(1, j, 9, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    total++;
    if (ovf !== 1'b1) $display("FAIL wrap_ovf got ovf=%b want ovf=1", ovf);
    else passed++;
    step(0, 0, 0, 0, 0, 0);
    total++;
    if (ovf !== 1'b0) $display("FAIL wrap_pulse got ovf=%b want ovf=0", ovf);
    else passed++;
    // inc with wr_en: the write wins and no increment happens.
    step(1, 0, 5, 0, 1, 0);
    for (int k = 0; k < 34; k++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx})
        $display("FAIL wrap_scan c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
    end
  endtask

  task automatic test_hex_inc();
    do_reset();
    step(1, 0, 15, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 34; k++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx})
        $display("FAIL hex_inc c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
      if (an === 4'hE) begin
        total++;
        if (seg !== 8'hC0) $display("FAIL hex_slot0 got seg=%h want seg=C0", seg);
        else passed++;
      end
    end
  endtask

  task automatic test_mask_and_reset();
    do_reset();
    step(1, 1, 8, 1, 0, 0);
    blank_mask = 4'b0010;
    for (int k = 0; k < 36; k++) begin
      step(0, 0, 0, 0, 0, 0);
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx} || an[1] !== 1'b1)
        $display("FAIL mask_scan c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
    end
    // Run into the middle of a DRIVE interval on digit 2, then reset asynchronously.
    blank_mask = 4'b0000;
    for (int k = 0; k < 64 && !((c % P) == 5 && ((c / P) % N) == 2); k++)
      step(0, 0, 0, 0, 0, 0);
    total++;
    if (an !== 4'hB) $display("FAIL pre_reset_drive got an=%h want an=B", an);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (an !== 4'hF || digit_idx !== 2'd0 || seg !== 8'hFF)
      $display("FAIL mid_reset got an=%h idx=%0d seg=%h want an=F idx=0 seg=FF", an, digit_idx, seg);
    else passed++;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    step(1, $urandom_range(0, 3), $urandom_range(0, 15), 1'($urandom), 0, 0);
        2, 3, 4: step(0, 0, 0, 0, 1, 0);
        5:       step(0, 0, 0, 0, 0, 1);
        6:       step(1, $urandom_range(0, 3), $urandom_range(0, 15), 1, 0, 1);
        7:       step(1, $urandom_range(0, 3), $urandom_range(0, 15), 0, 1, 0);
        default: step(0, 0, 0, 0, 0, 0);
      endcase
      total++;
      if ({an, seg, ovf, digit_idx} !== {e_an, e_seg, m_ovf, e_idx})
        $display("FAIL random c=%0d got an=%h seg=%h ovf=%b idx=%0d want an=%h seg=%h ovf=%b idx=%0d",
                 c, an, seg, ovf, digit_idx, e_an, e_seg, m_ovf, e_idx);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_inc_bcd();
    test_wrap();
    test_hex_inc();
    test_mask_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
